// File: rtl/mc_sequencer.sv
// -----------------------------------------------------------------------------
// mc_sequencer
// Multi-cycle control sequencer for a simple load/store core. It walks each
// instruction through FETCH -> DECODE -> EXEC -> (MEM) -> WB. It handshakes
// with the instruction and data memories, and it gates the decoder's register
// and PC controls. It counts retired instructions and latches sticky
// illegal-instruction and bus-timeout flags. A fault parks the sequencer in
// HALT until reset.
//
// Parameters
//   TIMEOUT        wait cycles allowed on a memory handshake (1..255)
// Ports
//   i_clk          clock, rising edge
//   i_reset        asynchronous active-high reset
//   i_imem_ready   instruction memory acknowledge
//   i_dmem_ready   data memory acknowledge
//   i_insn_vld     decoder: instruction is legal
//   i_is_load      decoder: instruction is a load
//   i_is_store     decoder: instruction is a store
//   i_reg_wen_dec  decoder: register write enable
//   i_pc_sel_dec   decoder: PC select (1 = ALU target)
//   o_imem_req     instruction fetch request
//   o_ir_we        instruction register load strobe
//   o_dmem_req     data memory request
//   o_dmem_we      data memory write enable
//   o_reg_wen      gated register-file write enable
//   o_pc_we        PC update strobe
//   o_pc_sel       PC select, meaningful while o_pc_we = 1
//   o_retire       one-cycle pulse per completed instruction
//   o_retire_cnt   retired instruction count, wraps
//   o_illegal      sticky illegal-instruction flag
//   o_bus_err      sticky memory-timeout flag
//   o_state        current state code
// -----------------------------------------------------------------------------
module mc_sequencer #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_imem_ready,
  input  logic        i_dmem_ready,
  input  logic        i_insn_vld,
  input  logic        i_is_load,
  input  logic        i_is_store,
  input  logic        i_reg_wen_dec,
  input  logic        i_pc_sel_dec,
  output logic        o_imem_req,
  output logic        o_ir_we,
  output logic        o_dmem_req,
  output logic        o_dmem_we,
  output logic        o_reg_wen,
  output logic        o_pc_we,
  output logic        o_pc_sel,
  output logic        o_retire,
  output logic [31:0] o_retire_cnt,
  output logic        o_illegal,
  output logic        o_bus_err,
  output logic [2:0]  o_state
);

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_t;

  // A handshake times out when a non-acknowledged cycle would take the
  // counter to TIMEOUT. An acknowledge in that same cycle still succeeds.
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 32'd1);

  state_t      state_r;
  state_t      next_state_s;
  logic [7:0]  wait_cnt_r;
  logic [31:0] retire_cnt_r;
  logic        illegal_r;
  logic        bus_err_r;

  logic        req_pending_s;
  logic        req_ready_s;
  logic        timeout_s;
  logic        wait_clr_s;
  logic        set_illegal_s;
  logic        set_bus_err_s;

  assign timeout_s    = (wait_cnt_r == WAIT_LAST);
  assign wait_clr_s   = (next_state_s != state_r) &&
                        ((next_state_s == ST_FETCH) || (next_state_s == ST_MEM));
  assign o_state      = state_r;
  assign o_retire_cnt = retire_cnt_r;
  assign o_illegal    = illegal_r;
  assign o_bus_err    = bus_err_r;

  // State register; reset parks the sequencer in FETCH immediately.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_r <= ST_FETCH;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state and output decode from the state register and decoder flags.
  always_comb begin
    next_state_s  = state_r;
    o_imem_req    = 1'b0;
    o_ir_we       = 1'b0;
    o_dmem_req    = 1'b0;
    o_dmem_we     = 1'b0;
    o_reg_wen     = 1'b0;
    o_pc_we       = 1'b0;
    o_pc_sel      = 1'b0;
    o_retire      = 1'b0;
    req_pending_s = 1'b0;
    req_ready_s   = 1'b0;
    set_illegal_s = 1'b0;
    set_bus_err_s = 1'b0;
    case (state_r)
      ST_FETCH: begin
        o_imem_req    = 1'b1;
        req_pending_s = 1'b1;
        req_ready_s   = i_imem_ready;
        if (i_imem_ready) begin
          o_ir_we      = 1'b1;
          next_state_s = ST_DECODE;
        end else if (timeout_s) begin
          set_bus_err_s = 1'b1;
          next_state_s  = ST_HALT;
        end else begin
          next_state_s = ST_FETCH;
        end
      end
      ST_DECODE: begin
        if (!i_insn_vld) begin
          set_illegal_s = 1'b1;
          next_state_s  = ST_HALT;
        end else begin
          next_state_s = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (i_is_load || i_is_store) begin
          next_state_s = ST_MEM;
        end else begin
          next_state_s = ST_WB;
        end
      end
      ST_MEM: begin
        o_dmem_req    = 1'b1;
        o_dmem_we     = i_is_store;
        req_pending_s = 1'b1;
        req_ready_s   = i_dmem_ready;
        if (i_dmem_ready) begin
          // A store has nothing to write back, so it retires here.
          if (i_is_store) begin
            o_pc_we      = 1'b1;
            o_pc_sel     = 1'b0;
            o_retire     = 1'b1;
            next_state_s = ST_FETCH;
          end else begin
            next_state_s = ST_WB;
          end
        end else if (timeout_s) begin
          set_bus_err_s = 1'b1;
          next_state_s  = ST_HALT;
        end else begin
          next_state_s = ST_MEM;
        end
      end
      ST_WB: begin
        o_reg_wen    = i_reg_wen_dec;
        o_pc_we      = 1'b1;
        o_pc_sel     = i_pc_sel_dec;
        o_retire     = 1'b1;
        next_state_s = ST_FETCH;
      end
      ST_HALT: begin
        next_state_s = ST_HALT;
      end
      default: begin
        // Unused codes 6-7 are treated as a fault.
        next_state_s = ST_HALT;
      end
    endcase
  end

  // Handshake wait counter: cleared on entering a request state.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      wait_cnt_r <= 8'd0;
    end else if (wait_clr_s) begin
      wait_cnt_r <= 8'd0;
    end else if (req_pending_s && !req_ready_s) begin
      wait_cnt_r <= wait_cnt_r + 8'd1;
    end else begin
      wait_cnt_r <= wait_cnt_r;
    end
  end

  // Retired instruction counter; wraps naturally at 32 bits.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      retire_cnt_r <= 32'd0;
    end else if (o_retire) begin
      retire_cnt_r <= retire_cnt_r + 32'd1;
    end else begin
      retire_cnt_r <= retire_cnt_r;
    end
  end

  // Sticky fault flags, cleared only by reset.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      illegal_r <= 1'b0;
      bus_err_r <= 1'b0;
    end else begin
      illegal_r <= illegal_r | set_illegal_s;
      bus_err_r <= bus_err_r | set_bus_err_s;
    end
  end

endmodule

// File: tb/tb_mc_sequencer.sv
// -----------------------------------------------------------------------------
// tb_mc_sequencer
// Directed bench for mc_sequencer with TIMEOUT = 4. The stimulus process
// drives one cycle at a time, shortly after each rising edge. For every cycle
// it pushes a hand-computed expectation into a queue. That expectation holds
// the state, the eight strobes, both flags and the retire count. A monitor
// pops one expectation on each falling edge and compares it against the DUT.
// -----------------------------------------------------------------------------
module tb_mc_sequencer;

  logic        i_clk;
  logic        i_reset;
  logic        i_imem_ready;
  logic        i_dmem_ready;
  logic        i_insn_vld;
  logic        i_is_load;
  logic        i_is_store;
  logic        i_reg_wen_dec;
  logic        i_pc_sel_dec;
  logic        o_imem_req;
  logic        o_ir_we;
  logic        o_dmem_req;
  logic        o_dmem_we;
  logic        o_reg_wen;
  logic        o_pc_we;
  logic        o_pc_sel;
  logic        o_retire;
  logic [31:0] o_retire_cnt;
  logic        o_illegal;
  logic        o_bus_err;
  logic [2:0]  o_state;

  mc_sequencer #(.TIMEOUT(4)) dut (
    .i_clk         (i_clk),
    .i_reset       (i_reset),
    .i_imem_ready  (i_imem_ready),
    .i_dmem_ready  (i_dmem_ready),
    .i_insn_vld    (i_insn_vld),
    .i_is_load     (i_is_load),
    .i_is_store    (i_is_store),
    .i_reg_wen_dec (i_reg_wen_dec),
    .i_pc_sel_dec  (i_pc_sel_dec),
    .o_imem_req    (o_imem_req),
    .o_ir_we       (o_ir_we),
    .o_dmem_req    (o_dmem_req),
    .o_dmem_we     (o_dmem_we),
    .o_reg_wen     (o_reg_wen),
    .o_pc_we       (o_pc_we),
    .o_pc_sel      (o_pc_sel),
    .o_retire      (o_retire),
    .o_retire_cnt  (o_retire_cnt),
    .o_illegal     (o_illegal),
    .o_bus_err     (o_bus_err),
    .o_state       (o_state)
  );

  // Strobe order: imem_req ir_we dmem_req dmem_we reg_wen pc_we pc_sel retire
  localparam logic [7:0] SB_NONE   = 8'h00;
  localparam logic [7:0] SB_F_WAIT = 8'h80;
  localparam logic [7:0] SB_F_ACK  = 8'hC0;
  localparam logic [7:0] SB_M_LD   = 8'h20;
  localparam logic [7:0] SB_M_STA  = 8'h35;
  localparam logic [7:0] SB_WB_RW  = 8'h0D;
  localparam logic [7:0] SB_WB_BR  = 8'h07;
  localparam logic [7:0] SB_WB_JR  = 8'h0F;

  localparam logic [2:0] S_F = 3'd0;
  localparam logic [2:0] S_D = 3'd1;
  localparam logic [2:0] S_E = 3'd2;
  localparam logic [2:0] S_M = 3'd3;
  localparam logic [2:0] S_W = 3'd4;
  localparam logic [2:0] S_H = 3'd5;

  typedef struct packed {
    logic [2:0]  state;
    logic [7:0]  sb;
    logic        ill;
    logic        be;
    logic [31:0] cnt;
  } exp_t;

  exp_t        exp_q[$];
  string       nm_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] exp_cnt  = 32'd0;
  logic        exp_ill  = 1'b0;
  logic        exp_be   = 1'b0;

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Monitor: compare one queued expectation per falling edge.
  always @(negedge i_clk) begin
    exp_t  e;
    exp_t  a;
    string nm;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      nm = nm_q.pop_front();
      a.state = o_state;
      a.sb    = {o_imem_req, o_ir_we, o_dmem_req, o_dmem_we,
                 o_reg_wen, o_pc_we, o_pc_sel, o_retire};
      a.ill   = o_illegal;
      a.be    = o_bus_err;
      a.cnt   = o_retire_cnt;
      n_checks = n_checks + 1;
      if (a === e) begin
        n_pass = n_pass + 1;
      end else begin
        $display("FAIL %s: got state=%0d sb=%b ill=%b be=%b cnt=%h, expected state=%0d sb=%b ill=%b be=%b cnt=%h",
                 nm, a.state, a.sb, a.ill, a.be, a.cnt,
                 e.state, e.sb, e.ill, e.be, e.cnt);
      end
    end
  end

  task automatic set_in(input logic imem, input logic dmem, input logic vld,
                        input logic ld, input logic st, input logic rw,
                        input logic ps);
    i_imem_ready  = imem;
    i_dmem_ready  = dmem;
    i_insn_vld    = vld;
    i_is_load     = ld;
    i_is_store    = st;
    i_reg_wen_dec = rw;
    i_pc_sel_dec  = ps;
  endtask

  task automatic push_exp(input string nm, input logic [2:0] st, input logic [7:0] sb);
    exp_t e;
    e.state = st;
    e.sb    = sb;
    e.ill   = exp_ill;
    e.be    = exp_be;
    e.cnt   = exp_cnt;
    exp_q.push_back(e);
    nm_q.push_back(nm);
    if (sb[0]) exp_cnt = exp_cnt + 32'd1;
  endtask

  // One clock cycle with its expected outputs.
  task automatic cyc(input string nm, input logic [2:0] st, input logic [7:0] sb);
    push_exp(nm, st, sb);
    @(posedge i_clk);
    #1;
  endtask

  // Assert reset between edges and expect FETCH with everything cleared.
  task automatic reset_pulse(input string nm);
    i_imem_ready = 1'b0;
    #1;
    i_reset = 1'b1;
    exp_cnt = 32'd0;
    exp_ill = 1'b0;
    exp_be  = 1'b0;
    push_exp(nm, S_F, SB_F_WAIT);
    @(posedge i_clk);
    #1;
    i_reset = 1'b0;
  endtask

  task automatic alu(input string nm, input logic rw, input logic ps, input logic [7:0] sb_wb);
    set_in(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, rw, ps);
    cyc({nm, "_f"}, S_F, SB_F_ACK);
    cyc({nm, "_d"}, S_D, SB_NONE);
    cyc({nm, "_e"}, S_E, SB_NONE);
    cyc({nm, "_w"}, S_W, sb_wb);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    i_reset = 1'b1;
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge i_clk);
    #1;
    reset_pulse("reset");

    // Zero-wait ALU instruction and a branch.
    alu("alu", 1'b1, 1'b0, SB_WB_RW);
    alu("branch", 1'b0, 1'b1, SB_WB_BR);

    // Load with data ready three cycles late; ready lands on the last
    // allowed wait cycle.
    set_in(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    cyc("ld_f", S_F, SB_F_ACK);
    cyc("ld_d", S_D, SB_NONE);
    cyc("ld_e", S_E, SB_NONE);
    cyc("ld_m0", S_M, SB_M_LD);
    cyc("ld_m1", S_M, SB_M_LD);
    cyc("ld_m2", S_M, SB_M_LD);
    i_dmem_ready = 1'b1;
    cyc("ld_m3", S_M, SB_M_LD);
    cyc("ld_w", S_W, SB_WB_RW);

    // Zero-wait store retires in MEM and never writes the register file.
    set_in(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    cyc("st_f", S_F, SB_F_ACK);
    cyc("st_d", S_D, SB_NONE);
    cyc("st_e", S_E, SB_NONE);
    cyc("st_m", S_M, SB_M_STA);

    // Fetch acknowledged on its fourth cycle: no timeout.
    set_in(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc("late_f0", S_F, SB_F_WAIT);
    cyc("late_f1", S_F, SB_F_WAIT);
    cyc("late_f2", S_F, SB_F_WAIT);
    i_imem_ready = 1'b1;
    cyc("late_f3", S_F, SB_F_ACK);
    cyc("late_d", S_D, SB_NONE);
    cyc("late_e", S_E, SB_NONE);
    cyc("late_w", S_W, SB_WB_RW);

    // Retire counter wraps from all-ones to zero.
    force dut.retire_cnt_r = 32'hFFFF_FFFF;
    #1;
    release dut.retire_cnt_r;
    exp_cnt = 32'hFFFF_FFFF;
    alu("wrap", 1'b1, 1'b0, SB_WB_RW);
    alu("post_wrap", 1'b1, 1'b0, SB_WB_RW);

    // Reset between edges while in WB: state returns to FETCH at once, no retire.
    set_in(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc("rwb_f", S_F, SB_F_ACK);
    cyc("rwb_d", S_D, SB_NONE);
    cyc("rwb_e", S_E, SB_NONE);
    reset_pulse("rst_mid_wb");
    alu("after_rst", 1'b1, 1'b1, SB_WB_JR);

    // Reset while a store waits in MEM: dmem request drops with no retire.
    set_in(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc("rmem_f", S_F, SB_F_ACK);
    cyc("rmem_d", S_D, SB_NONE);
    cyc("rmem_e", S_E, SB_NONE);
    reset_pulse("rst_mid_mem");
    alu("after_rst2", 1'b1, 1'b0, SB_WB_RW);

    // Illegal instruction: HALT forever, all strobes low even with ready high.
    set_in(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    cyc("ill_f", S_F, SB_F_ACK);
    cyc("ill_d", S_D, SB_NONE);
    exp_ill = 1'b1;
    cyc("ill_h0", S_H, SB_NONE);
    cyc("ill_h1", S_H, SB_NONE);
    cyc("ill_h2", S_H, SB_NONE);
    reset_pulse("rst_after_ill");

    // Fetch never acknowledged: bus error after four wait cycles.
    set_in(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc("to_f0", S_F, SB_F_WAIT);
    cyc("to_f1", S_F, SB_F_WAIT);
    cyc("to_f2", S_F, SB_F_WAIT);
    cyc("to_f3", S_F, SB_F_WAIT);
    exp_be = 1'b1;
    cyc("to_h0", S_H, SB_NONE);
    i_imem_ready = 1'b1;
    cyc("to_h1", S_H, SB_NONE);
    reset_pulse("rst_final");

    // Let the monitor drain, bounded.
    for (int k = 0; k < 4; k++) begin
      if (exp_q.size() > 0) @(negedge i_clk);
    end
    #1;
    n_checks = n_checks + 1;
    if (exp_q.size() == 0) begin
      n_pass = n_pass + 1;
    end else begin
      $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
